// File: rtl/multiple_instructions.sv
// multiple_instructions: single-cycle RV32I core with one unified 32-bit-word
// memory shared by instruction fetch and data access.

// Register file x0..x31; combinational reads, write on the rising edge.
module regfile (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rs1_data_o,
  output logic [31:0] rs2_data_o
);
  reg [31:0] memory [0:31];

  // Reset clears every register and wins over a write in the same cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) memory[i] <= '0;
    end else if (we_i && (rd_i != 5'd0)) begin
      memory[rd_i] <= wd_i;
    end
  end

  assign rs1_data_o = (rs1_i == 5'd0) ? '0 : memory[rs1_i];
  assign rs2_data_o = (rs2_i == 5'd0) ? '0 : memory[rs2_i];
endmodule

// Decode, register file, ALU, branch and load/store formatting.
module datapath (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] ld_word_i,
  output logic [29:0] dmem_word_addr_o,
  output logic        st_we_o,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_data_o,
  output logic [31:0] pc_next_o
);
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;

  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [31:0] rs1_v;
  logic [31:0] rs2_v;
  logic [31:0] pc_plus4;
  logic [31:0] dmem_addr;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        rf_we_d;
  logic [31:0] rf_wd_d;

  function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    logic signed [31:0] sra_s;
    a_s   = a;
    b_s   = b;
    sra_s = a_s >>> b[4:0];
    case (f3)
      3'd0:    alu = alt ? (a - b) : (a + b);
      3'd1:    alu = a << b[4:0];
      3'd2:    alu = {31'd0, (a_s < b_s)};
      3'd3:    alu = {31'd0, (a < b)};
      3'd4:    alu = a ^ b;
      3'd5:    alu = alt ? sra_s : (a >> b[4:0]);
      3'd6:    alu = a | b;
      default: alu = a & b;
    endcase
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3,
                                        input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    a_s = a;
    b_s = b;
    case (f3)
      3'd0:    branch_taken = (a == b);
      3'd1:    branch_taken = (a != b);
      3'd4:    branch_taken = (a_s < b_s);
      3'd5:    branch_taken = (a_s >= b_s);
      3'd6:    branch_taken = (a < b);
      3'd7:    branch_taken = (a >= b);
      default: branch_taken = 1'b0;
    endcase
  endfunction

  // Immediate shifts carry funct7 in the immediate; only the RV32I encodings retire.
  function automatic logic imm_op_legal(input logic [2:0] f3, input logic [6:0] f7);
    case (f3)
      3'd1:    imm_op_legal = (f7 == 7'h00);
      3'd5:    imm_op_legal = (f7 == 7'h00) || (f7 == 7'h20);
      default: imm_op_legal = 1'b1;
    endcase
  endfunction

  function automatic logic reg_op_legal(input logic [2:0] f3, input logic [6:0] f7);
    reg_op_legal = (f7 == 7'h00) ||
                   ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
  endfunction

  assign opcode = instr_i[6:0];
  assign rd     = instr_i[11:7];
  assign funct3 = instr_i[14:12];
  assign rs1    = instr_i[19:15];
  assign rs2    = instr_i[24:20];
  assign funct7 = instr_i[31:25];

  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                  instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'd0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                  instr_i[30:21], 1'b0};

  regfile reg_mem (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .we_i       (rf_we_d),
    .rs1_i      (rs1),
    .rs2_i      (rs2),
    .rd_i       (rd),
    .wd_i       (rf_wd_d),
    .rs1_data_o (rs1_v),
    .rs2_data_o (rs2_v)
  );

  assign pc_plus4         = pc_i + 32'd4;
  assign dmem_addr        = rs1_v + ((opcode == OP_STORE) ? imm_s : imm_i);
  assign dmem_word_addr_o = dmem_addr[31:2];
  assign ld_byte          = 8'(ld_word_i >> {dmem_addr[1:0], 3'b000});
  assign ld_half          = dmem_addr[1] ? ld_word_i[31:16] : ld_word_i[15:0];

  // Per-instruction register write, store request and next pc; anything unrecognised retires as a no-op
  always_comb begin
    rf_we_d   = 1'b0;
    rf_wd_d   = '0;
    st_we_o   = 1'b0;
    st_be_o   = '0;
    st_data_o = '0;
    pc_next_o = pc_plus4;
    case (opcode)
      OP_LUI: begin
        rf_we_d = 1'b1;
        rf_wd_d = imm_u;
      end
      OP_AUIPC: begin
        rf_we_d = 1'b1;
        rf_wd_d = pc_i + imm_u;
      end
      OP_JAL: begin
        rf_we_d   = 1'b1;
        rf_wd_d   = pc_plus4;
        pc_next_o = pc_i + imm_j;
      end
      OP_JALR: begin
        if (funct3 == 3'd0) begin
          rf_we_d   = 1'b1;
          rf_wd_d   = pc_plus4;
          pc_next_o = (rs1_v + imm_i) & ~32'd1;
        end
      end
      OP_BRANCH: begin
        if (branch_taken(funct3, rs1_v, rs2_v)) pc_next_o = pc_i + imm_b;
      end
      OP_LOAD: begin
        rf_we_d = 1'b1;
        case (funct3)
          3'd0:    rf_wd_d = {{24{ld_byte[7]}}, ld_byte};
          3'd1:    rf_wd_d = {{16{ld_half[15]}}, ld_half};
          3'd2:    rf_wd_d = ld_word_i;
          3'd4:    rf_wd_d = {24'd0, ld_byte};
          3'd5:    rf_wd_d = {16'd0, ld_half};
          default: rf_we_d = 1'b0;
        endcase
      end
      OP_STORE: begin
        st_we_o = 1'b1;
        case (funct3)
          3'd0: begin
            st_be_o   = 4'b0001 << dmem_addr[1:0];
            st_data_o = {4{rs2_v[7:0]}};
          end
          3'd1: begin
            st_be_o   = dmem_addr[1] ? 4'b1100 : 4'b0011;
            st_data_o = {2{rs2_v[15:0]}};
          end
          3'd2: begin
            st_be_o   = 4'b1111;
            st_data_o = rs2_v;
          end
          default: st_we_o = 1'b0;
        endcase
      end
      OP_IMM: begin
        rf_we_d = imm_op_legal(funct3, funct7);
        rf_wd_d = alu(funct3, (funct3 == 3'd5) && funct7[5], rs1_v, imm_i);
      end
      OP_REG: begin
        rf_we_d = reg_op_legal(funct3, funct7);
        rf_wd_d = alu(funct3, funct7[5], rs1_v, rs2_v);
      end
      default: ;
    endcase
  end
endmodule

// Core top: owns the pc and the unified program/data memory.
module multiple_instructions #(
  parameter int PROGRAM_MEMORY_SIZE_WORDS = 256
) (
  input logic clk,
  input logic reset
);
  localparam int IDX_W = (PROGRAM_MEMORY_SIZE_WORDS > 1) ?
                         $clog2(PROGRAM_MEMORY_SIZE_WORDS) : 1;

  reg [31:0] program_memory [0:PROGRAM_MEMORY_SIZE_WORDS-1];
  reg [31:0] pc;

  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] data_idx;
  logic [29:0]      dmem_word_addr;
  logic [31:0]      ld_word;
  logic             st_we;
  logic [3:0]       st_be;
  logic [31:0]      st_data;
  logic [31:0]      pc_d;
  wire  [31:0]      instruction;

  // Word addresses wrap around the memory size, for fetch and data alike.
  function automatic logic [IDX_W-1:0] word_index(input logic [29:0] word_addr);
    word_index = IDX_W'(word_addr % 30'(PROGRAM_MEMORY_SIZE_WORDS));
  endfunction

  assign fetch_idx   = word_index(pc[31:2]);
  assign data_idx    = word_index(dmem_word_addr);
  assign instruction = program_memory[fetch_idx];
  assign ld_word     = program_memory[data_idx];

  datapath single_instr (
    .clk_i            (clk),
    .rst_i            (reset),
    .instr_i          (instruction),
    .pc_i             (pc),
    .ld_word_i        (ld_word),
    .dmem_word_addr_o (dmem_word_addr),
    .st_we_o          (st_we),
    .st_be_o          (st_be),
    .st_data_o        (st_data),
    .pc_next_o        (pc_d)
  );

  // Program counter: one instruction retires per edge; reset restarts at 0
  always_ff @(posedge clk) begin
    if (reset) pc <= '0;
    else       pc <= pc_d;
  end

  // Byte-enabled store; memory contents are never cleared by reset
  always_ff @(posedge clk) begin
    if (!reset && st_we) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) program_memory[data_idx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_multiple_instructions.sv
// Bench for multiple_instructions: instruction-level reference model compared
// every cycle, plus directed programs with hand-computed expectations.
module tb_multiple_instructions;
  localparam int MEMW = 256;

  logic clk = 1'b0;
  logic reset = 1'b1;

  multiple_instructions #(.PROGRAM_MEMORY_SIZE_WORDS(MEMW)) dut (
    .clk   (clk),
    .reset (reset)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  logic [31:0] mmem [MEMW];
  logic [31:0] mreg [32];
  logic [31:0] mpc;
  int rbad;
  int mbad;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rf(input int i);
    return dut.single_instr.reg_mem.memory[i];
  endfunction

  function automatic logic [31:0] sx(input logic [31:0] v, input int bits);
    logic [31:0] m;
    m = 32'hFFFF_FFFF << bits;
    return v[bits-1] ? (v | m) : (v & ~m);
  endfunction

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                        input int rd, input int op);
    logic [31:0] im;
    im = imm;
    return {im[11:0], 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] im;
    im = imm;
    return {im[11:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] im;
    im = imm;
    return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:1], im[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [31:0] im;
    im = imm;
    return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'h6F};
  endfunction

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                        input int f3, input int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction

  task automatic put_word(input int idx, input logic [31:0] val);
    dut.program_memory[idx] = val;
    mmem[idx] = val;
  endtask

  task automatic fill_nop();
    for (int i = 0; i < MEMW; i++) put_word(i, 32'h0000_0013);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  // ---------------- reference model: one instruction per call ----------------
  task automatic model_step();
    logic [31:0] ins, a, b, ii, is, ib, iu, ij, nxt, addr, w, r;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    int          rd, sh, idx;
    bit          wr, t;
    ins = mmem[(mpc >> 2) % MEMW];
    op  = ins[6:0];
    rd  = ins[11:7];
    f3  = ins[14:12];
    f7  = ins[31:25];
    a   = mreg[ins[19:15]];
    b   = mreg[ins[24:20]];
    ii  = sx(ins >> 20, 12);
    is  = sx({20'd0, ins[31:25], ins[11:7]}, 12);
    ib  = sx({19'd0, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, 13);
    iu  = ins & 32'hFFFF_F000;
    ij  = sx({11'd0, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, 21);
    nxt = mpc + 4;
    wr  = 1'b0;
    r   = '0;
    t   = 1'b0;
    case (op)
      7'h37: begin wr = 1'b1; r = iu; end
      7'h17: begin wr = 1'b1; r = mpc + iu; end
      7'h6F: begin wr = 1'b1; r = mpc + 4; nxt = mpc + ij; end
      7'h67: if (f3 == 3'd0) begin wr = 1'b1; r = mpc + 4; nxt = (a + ii) & 32'hFFFF_FFFE; end
      7'h63: begin
        case (f3)
          3'd0: t = (a == b);
          3'd1: t = (a != b);
          3'd4: t = ((a ^ 32'h8000_0000) <  (b ^ 32'h8000_0000));
          3'd5: t = ((a ^ 32'h8000_0000) >= (b ^ 32'h8000_0000));
          3'd6: t = (a < b);
          3'd7: t = (a >= b);
          default: t = 1'b0;
        endcase
        if (t) nxt = mpc + ib;
      end
      7'h03: begin
        addr = a + ii;
        w = mmem[(addr >> 2) % MEMW];
        wr = 1'b1;
        case (f3)
          3'd0: r = sx((w >> (8 * addr[1:0])) & 32'hFF, 8);
          3'd1: r = sx((w >> (16 * addr[1])) & 32'hFFFF, 16);
          3'd2: r = w;
          3'd4: r = (w >> (8 * addr[1:0])) & 32'hFF;
          3'd5: r = (w >> (16 * addr[1])) & 32'hFFFF;
          default: wr = 1'b0;
        endcase
      end
      7'h23: begin
        addr = a + is;
        idx = (addr >> 2) % MEMW;
        case (f3)
          3'd0: begin
            sh = 8 * addr[1:0];
            mmem[idx] = (mmem[idx] & ~(32'hFF << sh)) | ((b & 32'hFF) << sh);
          end
          3'd1: begin
            sh = 16 * addr[1];
            mmem[idx] = (mmem[idx] & ~(32'hFFFF << sh)) | ((b & 32'hFFFF) << sh);
          end
          3'd2: mmem[idx] = b;
          default: ;
        endcase
      end
      7'h13, 7'h33: begin
        logic [31:0] y;
        y  = (op == 7'h13) ? ii : b;
        sh = y[4:0];
        wr = 1'b1;
        case (f3)
          3'd0: r = (op == 7'h33 && f7 == 7'h20) ? a - y : a + y;
          3'd1: r = a << sh;
          3'd2: r = ((a ^ 32'h8000_0000) < (y ^ 32'h8000_0000)) ? 1 : 0;
          3'd3: r = (a < y) ? 1 : 0;
          3'd4: r = a ^ y;
          3'd5: r = (f7 == 7'h20) ? ((a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0))
                                  : (a >> sh);
          3'd6: r = a | y;
          default: r = a & y;
        endcase
        if (op == 7'h13) begin
          if (f3 == 3'd1 && f7 != 7'h00) wr = 1'b0;
          if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) wr = 1'b0;
        end else begin
          if (!(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) wr = 1'b0;
        end
      end
      default: ;
    endcase
    if (wr && rd != 0) mreg[rd] = r;
    mpc = nxt;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      mpc = '0;
      for (int i = 0; i < 32; i++) mreg[i] = '0;
    end else begin
      model_step();
    end
  end

  // ---------------- per-cycle comparison against the model ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      n_tests++;
      if (dut.pc !== mpc) begin
        n_fail++;
        $display("FAIL pc_track: got %h expected %h", dut.pc, mpc);
      end
      rbad = -1;
      for (int i = 31; i >= 0; i--) if (rf(i) !== mreg[i]) rbad = i;
      n_tests++;
      if (rbad >= 0) begin
        n_fail++;
        $display("FAIL reg_track x%0d: got %h expected %h (pc %h)", rbad, rf(rbad), mreg[rbad], mpc);
      end
      mbad = -1;
      for (int i = MEMW - 1; i >= 0; i--) if (dut.program_memory[i] !== mmem[i]) mbad = i;
      n_tests++;
      if (mbad >= 0) begin
        n_fail++;
        $display("FAIL mem_track word %0d: got %h expected %h", mbad, dut.program_memory[mbad], mmem[mbad]);
      end
    end
  end

  // ---------------- random instruction generator ----------------
  function automatic logic [31:0] rand_instr();
    int k, rd, rs1, rs2, f3, f7, imm;
    k   = $urandom_range(0, 15);
    rd  = $urandom_range(0, 31);
    rs1 = $urandom_range(0, 31);
    rs2 = $urandom_range(0, 31);
    imm = $urandom_range(0, 4095);
    f3  = $urandom_range(0, 7);
    case (k)
      0:  return {20'($urandom), 5'(rd), 7'h37};
      1:  return {20'($urandom), 5'(rd), 7'h17};
      2:  return enc_j(($urandom_range(0, 16) - 8) * 4, rd);
      3:  return enc_i(imm, rs1, 0, rd, 7'h67);
      4: begin
        if (f3 == 2 || f3 == 3) f3 = f3 + 4;
        return enc_b(($urandom_range(0, 16) - 8) * 4, rs2, rs1, f3);
      end
      5: begin
        if (f3 == 3 || f3 >= 6) f3 = 2;
        return enc_i(imm, rs1, f3, rd, 7'h03);
      end
      6:  return enc_s(imm, rs2, rs1, $urandom_range(0, 2));
      7, 8, 9: begin
        if (f3 == 1) imm = imm & 31;
        else if (f3 == 5) imm = (imm & 31) | (($urandom_range(0, 1)) << 10);
        return enc_i(imm, rs1, f3, rd, 7'h13);
      end
      10, 11, 12: begin
        f7 = ((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return enc_r(f7, rs2, rs1, f3, rd);
      end
      13: begin
        case ($urandom_range(0, 3))
          0: return 32'h0000_000F;
          1: return 32'h0000_0073;
          2: return 32'h0010_0073;
          default: return 32'h3000_2573;
        endcase
      end
      14: return $urandom;
      default: return enc_i(imm, rs1, 0, rd, 7'h13);
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    fill_nop();
    @(posedge clk);
    #3;
    chk_en = 1'b1;
    tick(1);

    // reset state and NOP stream
    check("rst_pc", dut.pc, 32'd0);
    for (int i = 1; i < 32; i++) check($sformatf("rst_x%0d", i), rf(i), 32'd0);
    reset = 1'b0;
    tick(1);
    check("nop_pc_4", dut.pc, 32'h4);
    tick(1);
    check("nop_pc_8", dut.pc, 32'h8);

    // arithmetic, loads, byte store
    reset = 1'b1;
    fill_nop();
    put_word(0,  enc_i(5, 0, 0, 1, 7'h13));
    put_word(1,  enc_i(-3, 1, 0, 2, 7'h13));
    put_word(2,  enc_i(7, 0, 0, 0, 7'h13));
    put_word(3,  enc_i(32'h100, 0, 0, 3, 7'h13));
    put_word(4,  enc_i(1, 3, 4, 5, 7'h03));
    put_word(5,  enc_i(3, 3, 4, 6, 7'h03));
    put_word(6,  enc_i(3, 3, 0, 7, 7'h03));
    put_word(7,  enc_i(2, 3, 5, 8, 7'h03));
    put_word(8,  enc_i(32'hAB, 0, 0, 4, 7'h13));
    put_word(9,  enc_s(2, 4, 3, 0));
    put_word(10, enc_i(0, 3, 2, 9, 7'h03));
    put_word(64, 32'h80FF_1234);
    tick(2);
    reset = 1'b0;
    tick(3);
    check("addi_x1", rf(1), 32'd5);
    check("addi_x2", rf(2), 32'd2);
    check("addi_x0", rf(0), 32'd0);
    tick(8);
    check("lbu_b1", rf(5), 32'h12);
    check("lbu_b3", rf(6), 32'h80);
    check("lb_b3", rf(7), 32'hFFFF_FF80);
    check("lhu_h1", rf(8), 32'h80FF);
    check("sb_word", dut.program_memory[64], 32'h80AB_1234);
    check("lw_after_sb", rf(9), 32'h80AB_1234);
    check("model_lb", mreg[7], 32'hFFFF_FF80);
    check("model_sb", mmem[64], 32'h80AB_1234);
    tick(3);

    // one-cycle reset in the middle of the program
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("midrst_pc", dut.pc, 32'd0);
    check("midrst_x1", rf(1), 32'd0);
    check("midrst_x9", rf(9), 32'd0);
    check("midrst_mem", dut.program_memory[64], 32'h80AB_1234);
    tick(11);
    check("rerun_x9", rf(9), 32'h80AB_1234);

    // branches and JAL
    reset = 1'b1;
    fill_nop();
    put_word(0, enc_i(3, 0, 0, 1, 7'h13));
    put_word(1, enc_i(3, 0, 0, 2, 7'h13));
    put_word(2, enc_b(8, 2, 1, 0));
    put_word(3, enc_i(1, 0, 0, 10, 7'h13));
    put_word(4, enc_b(8, 2, 1, 1));
    put_word(8, enc_j(16, 1));
    tick(2);
    reset = 1'b0;
    tick(3);
    check("beq_taken_pc", dut.pc, 32'h10);
    tick(1);
    check("bne_not_taken_pc", dut.pc, 32'h14);
    tick(3);
    check("pre_jal_pc", dut.pc, 32'h20);
    tick(1);
    check("jal_pc", dut.pc, 32'h30);
    check("jal_link", rf(1), 32'h24);
    check("beq_skipped_x10", rf(10), 32'd0);
    check("model_jal_pc", mpc, 32'h30);

    // randomized programs filling the whole memory
    for (int run = 0; run < 6; run++) begin
      reset = 1'b1;
      for (int i = 0; i < MEMW; i++) put_word(i, rand_instr());
      tick(2);
      reset = 1'b0;
      tick(400);
    end

    chk_en = 1'b0;
    tick(1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/multiple_instructions.md
MULTIPLE_INSTRUCTIONS -- requirements
Module: multiple_instructions

Interface
REQ-001 SHALL have parameter PROGRAM_MEMORY_SIZE_WORDS, default 256, the number of 32-bit words in the unified memory.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have no other ports; the verification bench observes and loads state through the fixed hierarchical names in REQ-005..REQ-008.
REQ-005 SHALL hold memory as reg [31:0] program_memory[0:PROGRAM_MEMORY_SIZE_WORDS-1], preloadable by $readmemh, little-endian byte order within a word.
REQ-006 SHALL expose reg [31:0] pc: byte address of the current instruction.
REQ-007 SHALL expose wire [31:0] instruction = program_memory[pc[31:2]], combinational.
REQ-008 SHALL contain an instance single_instr (datapath) containing an instance reg_mem whose array reg [31:0] memory[0:31] is the register file x0..x31.

Function
REQ-009 SHALL be a single-cycle RV32I core: exactly one instruction retires per rising clk edge while reset is low.
REQ-010 SHALL implement LUI, AUIPC, JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU, LB, LH, LW, LBU, LHU, SB, SH, SW, ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI, ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA per the RV32I spec.
REQ-011 SHALL decode I/S/B/U/J immediates sign-extended to 32 bits; shift amounts use the low 5 bits.
REQ-012 SHALL set next pc = pc+4, except taken branch/JAL = pc+imm, and JALR = (rs1+imm) & ~1; JAL/JALR write pc+4 to rd.
REQ-013 SHALL read x0 as 0 always; writes to x0 are discarded.
REQ-014 SHALL read registers combinationally; rd write occurs at the same rising edge as the pc update.
REQ-015 SHALL use program_memory for both fetch and data; data address = rs1+imm; word index = addr[31:2] modulo PROGRAM_MEMORY_SIZE_WORDS (wraps).
REQ-016 SHALL read load data combinationally; LB/LBU select byte addr[1:0]; LH/LHU select halfword addr[1]; LW ignores addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-017 SHALL write stores at the rising edge: SB updates only byte addr[1:0], SH only halfword addr[1], SW whole word ignoring addr[1:0]; other bytes unchanged.
REQ-018 SHALL treat a store overwriting the current instruction word as visible to fetch from the next cycle only.
REQ-019 SHALL treat unsupported opcodes (including FENCE, ECALL, EBREAK, CSR) as no-ops: no register/memory write, pc+4.
REQ-020 SHALL wrap pc modulo 2^32; fetch index wraps as in REQ-015.

Reset
REQ-021 SHALL, at a rising edge with reset high, set pc=0 and all 32 registers to 0, and suppress all register and memory writes.
REQ-022 SHALL NOT modify program_memory on reset; preloaded contents persist across any reset, including mid-program.
REQ-023 SHALL fetch the word at address 0 at the first rising edge after reset deasserts.

Verification
REQ-024 Reset held 2 cycles, released -> pc=0, x1..x31=0; NOP stream -> pc=0,4,8 on successive edges.
REQ-025 addi x1,x0,5; addi x2,x1,-3; addi x0,x0,7 -> x1=5, x2=2, x0=0.
REQ-026 Word 0x80FF1234 preloaded at byte 0x100; base x3=0x100; lbu x5,1(x3) -> 0x12; lbu x6,3(x3) -> 0x80; lb x7,3(x3) -> 0xFFFFFF80; lhu x8,2(x3) -> 0x80FF.
REQ-027 x4=0xAB; sb x4,2(x3) -> word at 0x100 becomes 0x80AB1234; lw x9,0(x3) returns it.
REQ-028 x1=x2=3: beq x1,x2,+8 -> pc advances by 8; bne not taken -> pc+4; jal x1,+16 at pc=0x20 -> x1=0x24, pc=0x30.
REQ-029 Reset asserted mid-program for 1 cycle -> pc=0, registers 0, earlier stored data words still present.
